// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : pipe_stall_ctrl_pkg                                          |
// | Brief  : Bank indices, FSM encoding and hold/flush patterns shared by |
// |          the pipeline stall/flush sequencer.                          |
// | Rev    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
package pipe_stall_ctrl_pkg;

    localparam int BANK_IFID  = 0;
    localparam int BANK_IDEX  = 1;
    localparam int BANK_EXMEM = 2;
    localparam int BANK_MEMWB = 3;

    localparam logic [3:0] B_IFID  = 4'(1 << BANK_IFID);
    localparam logic [3:0] B_IDEX  = 4'(1 << BANK_IDEX);
    localparam logic [3:0] B_EXMEM = 4'(1 << BANK_EXMEM);
    localparam logic [3:0] B_MEMWB = 4'(1 << BANK_MEMWB);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        DIV = 2'd1,
        MEM = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] hold;
        logic [3:0] flush;
    } bank_ctrl_t;

    // Every stall pattern holds the banks upstream of the stalled stage and
    // flushes the bank directly behind it so a bubble moves forward.
    localparam bank_ctrl_t STALL_LU  = {B_IFID, B_IDEX};
    localparam bank_ctrl_t STALL_DIV = {B_IFID | B_IDEX, B_EXMEM};
    localparam bank_ctrl_t STALL_MEM = {B_IFID | B_IDEX | B_EXMEM, B_MEMWB};
    localparam bank_ctrl_t FLUSH_EXC = {4'b0000, B_IFID | B_IDEX | B_EXMEM};
    localparam bank_ctrl_t FLUSH_BR  = {4'b0000, B_IFID};

endpackage
`default_nettype wire

// File: rtl/stall_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : stall_wait_timer                                             |
// | Brief  : Loadable down-counter that saturates at zero.                |
// | Rev    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module stall_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // clear outranks load so an exception aborting a fresh divide wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : pipe_stall_ctrl                                              |
// | Brief  : Stall/flush sequencer for the 5-stage pipeline banks and PC. |
// | Rev    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES  = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use,
    input  logic        branch_redirect,
    input  logic        exc_mem,
    input  logic        div_start,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_hold,
    output logic [3:0]  stage_hold,
    output logic [3:0]  stage_flush,
    output logic        div_go,
    output logic        div_abort,
    output logic        div_done,
    output logic        mem_timeout,
    output logic [31:0] stall_count
);

    localparam logic [7:0] c_DIV_LOAD   = 8'(DIV_CYCLES - 1);
    localparam logic [9:0] c_MEM_LAST   = 10'(MEM_TIMEOUT - 1);
    localparam bit         c_DIV_SINGLE = (DIV_CYCLES == 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_mem_cnt;
    logic [9:0]  w_mem_cnt_nxt;
    logic [31:0] r_stall_count;

    logic [7:0]  w_div_cnt;
    logic        w_div_zero;
    logic        w_tmr_clear;
    logic        w_tmr_load;
    logic        w_tmr_dec;

    bank_ctrl_t  w_ctrl;
    logic        w_pc_hold;
    logic        w_div_go;
    logic        w_div_abort;
    logic        w_div_done;
    logic        w_mem_timeout;
    logic        w_run_mem_wait;
    logic        w_run_div;

    stall_wait_timer #(
        .WIDTH (8)
    ) u_div_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (c_DIV_LOAD),
        .i_dec      (w_tmr_dec),
        .o_count    (w_div_cnt)
    );

    assign w_div_zero     = (w_div_cnt == 8'd0);
    assign w_run_mem_wait = (r_state == RUN) && mem_req && !mem_ack;
    assign w_run_div      = (r_state == RUN) && div_start && !w_run_mem_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_mem_cnt     <= '0;
            r_stall_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_cnt <= w_mem_cnt_nxt;
            if (w_pc_hold) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_ctrl        = '0;
        w_pc_hold     = 1'b0;
        w_div_go      = 1'b0;
        w_div_abort   = 1'b0;
        w_div_done    = 1'b0;
        w_mem_timeout = 1'b0;
        w_state_nxt   = r_state;
        w_mem_cnt_nxt = r_mem_cnt;
        w_tmr_clear   = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_dec     = 1'b0;

        if (exc_mem) begin
            w_ctrl        = FLUSH_EXC;
            w_state_nxt   = RUN;
            w_mem_cnt_nxt = '0;
            w_tmr_clear   = 1'b1;
            w_div_abort   = (r_state == DIV) || w_run_div;
        end else begin
            case (r_state)
                MEM: begin
                    // lower-priority sources are not looked at until back in RUN
                    if (mem_ack) begin
                        w_state_nxt   = RUN;
                        w_mem_cnt_nxt = '0;
                    end else if (r_mem_cnt == c_MEM_LAST) begin
                        w_mem_timeout = 1'b1;
                        w_state_nxt   = RUN;
                        w_mem_cnt_nxt = '0;
                    end else begin
                        w_ctrl        = STALL_MEM;
                        w_pc_hold     = 1'b1;
                        w_mem_cnt_nxt = r_mem_cnt + 10'd1;
                    end
                end
                DIV: begin
                    if (w_div_zero) begin
                        w_div_done  = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_ctrl    = STALL_DIV;
                        w_pc_hold = 1'b1;
                        w_tmr_dec = 1'b1;
                    end
                end
                default: begin
                    if (w_run_mem_wait) begin
                        w_ctrl        = STALL_MEM;
                        w_pc_hold     = 1'b1;
                        w_state_nxt   = MEM;
                        w_mem_cnt_nxt = 10'd1;
                    end else if (w_run_div) begin
                        w_div_go = 1'b1;
                        if (c_DIV_SINGLE) begin
                            w_div_done = 1'b1;
                        end else begin
                            w_ctrl      = STALL_DIV;
                            w_pc_hold   = 1'b1;
                            w_tmr_load  = 1'b1;
                            w_state_nxt = DIV;
                        end
                    end else if (load_use) begin
                        w_ctrl    = STALL_LU;
                        w_pc_hold = 1'b1;
                    end else if (branch_redirect) begin
                        w_ctrl = FLUSH_BR;
                    end
                end
            endcase
        end
    end

    // outputs are forced low for the whole time rst is high, not just after an edge
    assign pc_hold     = rst ? 1'b0 : w_pc_hold;
    assign stage_hold  = rst ? 4'b0 : w_ctrl.hold;
    assign stage_flush = rst ? 4'b0 : w_ctrl.flush;
    assign div_go      = rst ? 1'b0 : w_div_go;
    assign div_abort   = rst ? 1'b0 : w_div_abort;
    assign div_done    = rst ? 1'b0 : w_div_done;
    assign mem_timeout = rst ? 1'b0 : w_mem_timeout;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_pipe_stall_ctrl                                           |
// | Brief  : Directed and randomized bench for pipe_stall_ctrl.           |
// | Rev    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

    localparam int c_DIVC = 16;
    localparam int c_MTO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use, branch_redirect, exc_mem, div_start, mem_req, mem_ack;
    logic        pc_hold, div_go, div_abort, div_done, mem_timeout;
    logic [3:0]  stage_hold, stage_flush;
    logic [31:0] stall_count;

    pipe_stall_ctrl #(
        .DIV_CYCLES  (c_DIVC),
        .MEM_TIMEOUT (c_MTO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_use        (load_use),
        .branch_redirect (branch_redirect),
        .exc_mem         (exc_mem),
        .div_start       (div_start),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_hold         (pc_hold),
        .stage_hold      (stage_hold),
        .stage_flush     (stage_flush),
        .div_go          (div_go),
        .div_abort       (div_abort),
        .div_done        (div_done),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks how long the current divide / memory wait has
    // been running and derives the outputs from the priority rules.
    bit          m_in_div, m_in_mem, n_in_div, n_in_mem;
    int          m_div_el, m_mem_el, n_div_el, n_mem_el;
    logic [31:0] m_stalls;
    logic [3:0]  e_hold, e_flush;
    logic        e_pc, e_go, e_abort, e_done, e_to;
    logic [12:0] e_vec, smp_vec;

    task automatic model_reset();
        m_in_div = 0; m_in_mem = 0; m_div_el = 0; m_mem_el = 0; m_stalls = '0;
    endtask

    task automatic model_eval(input bit lu, br, ex, ds, mr, ma);
        bit idle;
        e_hold = 0; e_flush = 0; e_pc = 0; e_go = 0; e_abort = 0; e_done = 0; e_to = 0;
        n_in_div = m_in_div; n_in_mem = m_in_mem; n_div_el = m_div_el; n_mem_el = m_mem_el;
        idle = !m_in_div && !m_in_mem;
        if (ex) begin
            e_flush = 4'b0111;
            n_in_div = 0; n_in_mem = 0; n_div_el = 0; n_mem_el = 0;
            e_abort = m_in_div || (idle && ds && !(mr && !ma));
        end else if (m_in_mem) begin
            if (ma) n_in_mem = 0;
            else if (m_mem_el == c_MTO - 1) begin e_to = 1; n_in_mem = 0; end
            else begin e_hold = 4'b0111; e_flush = 4'b1000; e_pc = 1; n_mem_el = m_mem_el + 1; end
        end else if (m_in_div) begin
            if (m_div_el == c_DIVC) begin e_done = 1; n_in_div = 0; end
            else begin e_hold = 4'b0011; e_flush = 4'b0100; e_pc = 1; n_div_el = m_div_el + 1; end
        end else if (mr && !ma) begin
            e_hold = 4'b0111; e_flush = 4'b1000; e_pc = 1; n_in_mem = 1; n_mem_el = 1;
        end else if (ds) begin
            e_go = 1;
            if (c_DIVC == 1) e_done = 1;
            else begin e_hold = 4'b0011; e_flush = 4'b0100; e_pc = 1; n_in_div = 1; n_div_el = 1; end
        end else if (lu) begin
            e_hold = 4'b0001; e_flush = 4'b0010; e_pc = 1;
        end else if (br) begin
            e_flush = 4'b0001;
        end
        e_vec = {e_pc, e_hold, e_flush, e_go, e_abort, e_done, e_to};
    endtask

    task automatic model_commit();
        m_in_div = n_in_div; m_in_mem = n_in_mem; m_div_el = n_div_el; m_mem_el = n_mem_el;
        if (e_pc) m_stalls = m_stalls + 32'd1;
    endtask

    // Called at posedge+1; drives one cycle, checks mid-cycle, returns at next posedge+1.
    task automatic cyc(input bit lu, br, ex, ds, mr, ma);
        load_use = lu; branch_redirect = br; exc_mem = ex;
        div_start = ds; mem_req = mr; mem_ack = ma;
        #4;
        model_eval(lu, br, ex, ds, mr, ma);
        smp_vec = {pc_hold, stage_hold, stage_flush, div_go, div_abort, div_done, mem_timeout};
        check("outputs", 64'(smp_vec), 64'(e_vec));
        check("stall_count", 64'(stall_count), 64'(m_stalls));
        model_commit();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sc0;
    bit r_lu, r_br, r_ex, r_ds, r_mr, r_ma, r_noack;

    initial begin
        rst = 1'b1;
        load_use = 0; branch_redirect = 0; exc_mem = 0; div_start = 0; mem_req = 0; mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        load_use = 1; div_start = 1; mem_req = 1; exc_mem = 1;
        #1;
        check("reset_outs", 64'({pc_hold, stage_hold, stage_flush, div_go, div_abort, div_done, mem_timeout}), 64'd0);
        check("reset_count", 64'(stall_count), 64'd0);
        load_use = 0; div_start = 0; mem_req = 0; exc_mem = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // load-use bubble
        cyc(1, 0, 0, 0, 0, 0);
        check("lu_pattern", 64'(smp_vec[12:4]), 64'({1'b1, 4'b0001, 4'b0010}));
        cyc(0, 0, 0, 0, 0, 0);
        check("lu_stall_count", 64'(stall_count), 64'd1);

        // divide with div_start held through the release cycle
        sc0 = stall_count;
        for (int i = 0; i <= c_DIVC; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (i == 0) check("div_go_t0", 64'(smp_vec[3]), 64'd1);
        end
        check("div_done_t16", 64'(smp_vec[1]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0);
        check("div_stall_total", 64'(stall_count - sc0), 64'(c_DIVC));

        // memory wait acked on the 4th cycle
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        check("mem_hold", 64'(smp_vec[12:4]), 64'({1'b1, 4'b0111, 4'b1000}));
        cyc(0, 0, 0, 0, 1, 1);
        check("mem_release", 64'(smp_vec[12:4]), 64'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // memory timeout
        for (int i = 0; i < c_MTO; i++) cyc(0, 0, 0, 0, 1, 0);
        check("mem_timeout_63", 64'(smp_vec[0]), 64'd1);
        cyc(0, 0, 0, 0, 0, 0);

        // exception at divide cycle 5
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("exc_abort", 64'({smp_vec[12:4], smp_vec[2]}), 64'({1'b0, 4'b0000, 4'b0111, 1'b1}));
        cyc(0, 0, 0, 0, 0, 0);
        check("exc_no_done", 64'(smp_vec[1]), 64'd0);

        // load_use beats branch_redirect
        cyc(1, 1, 0, 0, 0, 0);
        check("lu_over_br", 64'(smp_vec[11:4]), 64'({4'b0001, 4'b0010}));

        // async reset in the middle of a memory wait
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        mem_req = 1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_mem_outs", 64'({pc_hold, stage_hold, stage_flush, div_go, div_abort, div_done, mem_timeout}), 64'd0);
        check("rst_mid_mem_count", 64'(stall_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("run_after_rst", 64'(smp_vec[12:4]), 64'({1'b1, 4'b0111, 4'b1000}));
        cyc(0, 0, 0, 0, 1, 1);

        // randomized traffic with protocol-shaped div_start / mem_req
        r_ds = 0; r_mr = 0; r_noack = 0;
        for (int i = 0; i < 2500; i++) begin
            r_lu = ($urandom % 5) == 0;
            r_br = ($urandom % 4) == 0;
            r_ex = ($urandom % 40) == 0;
            if (!r_ds) r_ds = ($urandom % 8) == 0;
            if (!r_mr) begin
                r_mr    = ($urandom % 5) == 0;
                r_noack = ($urandom % 4) == 0;
            end
            r_ma = r_mr && !r_noack && (($urandom % 6) == 0);
            cyc(r_lu, r_br, r_ex, r_ds, r_mr, r_ma);
            if (e_done || e_abort || r_ex) r_ds = 0;
            if (r_ma || e_to || r_ex) r_mr = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage CPU pipeline. It drives the hold (wait_stop) and flush (rst) controls of the four inter-stage register banks and the PC register. Sources are load-use hazards, branch redirects, MEM-stage exceptions, a multi-cycle divider in EX and a data-memory request/ack handshake in MEM. Outputs are combinational from registered state plus current-cycle inputs, so a stall takes effect in the same cycle.

Parameters:
DIV_CYCLES, 16, divider latency in cycles; legal range is 1..255.
MEM_TIMEOUT, 64, maximum cycles to wait for mem_ack before giving up; legal range is 2..1023.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
load_use  in  1  hazard unit: the instruction in ID needs a load result that is still in EX.
branch_redirect  in  1  branch/jump taken, resolved in ID.
exc_mem  in  1  exception raised by the instruction in MEM.
div_start  in  1  the instruction in EX is a DIV/DIVU; held high while it stays in EX.
mem_req  in  1  the instruction in MEM is a load/store; held high until acked.
mem_ack  in  1  data memory completion, one-cycle pulse.
pc_hold  out  1  PC register holds its value.
stage_hold  out  4  hold/wait_stop per bank; bit0=IF/ID, bit1=ID/EX, bit2=EX/MEM, bit3=MEM/WB.
stage_flush  out  4  flush/rst per bank; same bit order as stage_hold.
div_go  out  1  one-cycle pulse that starts the divider.
div_abort  out  1  one-cycle pulse that kills an in-flight divide.
div_done  out  1  one-cycle pulse when the EX stall for a divide releases.
mem_timeout  out  1  one-cycle pulse when a memory wait times out.
stall_count  out  32  free-running count of cycles with pc_hold=1; wraps at 2^32.

Behaviour:
- Reset: state=RUN, div_cnt=0, mem_cnt=0, stall_count=0. All outputs are 0 while rst is high.
- Registered FSM states: RUN, DIV, MEM.
- Bank semantics: hold outranks flush. A bank with both bits 0 loads normally. The controller never asserts hold and flush on the same bit.
- Priority in every cycle: exc_mem > memory wait > divide > load_use > branch_redirect.
- exc_mem (any state):
  - stage_flush=4'b0111, stage_hold=0, pc_hold=0.
  - Next state RUN; div_cnt and mem_cnt cleared.
  - div_abort=1 if state is DIV or div_go would otherwise fire this cycle.
- Memory wait:
  - In RUN with mem_req=1 and mem_ack=1: no stall.
  - In RUN with mem_req=1 and mem_ack=0: stage_hold=4'b0111, stage_flush=4'b1000, pc_hold=1. Next state MEM, mem_cnt=1.
  - In MEM with mem_ack=0: same outputs, mem_cnt++.
  - In MEM with mem_ack=1: release (no hold/flush from this source), next state RUN.
  - In MEM with mem_ack=0 and mem_cnt==MEM_TIMEOUT-1: mem_timeout=1, release, next state RUN.
  - A div_start seen while in MEM is ignored; it is re-evaluated in RUN.
- Divide:
  - In RUN with div_start=1 (and no memory wait): div_go=1, stage_hold=4'b0011, stage_flush=4'b0100, pc_hold=1.
    - If DIV_CYCLES==1: no stall, div_done=1, stay in RUN.
    - Otherwise: next state DIV, div_cnt=DIV_CYCLES-1.
  - In DIV with div_cnt!=0: same hold/flush, div_cnt--.
  - In DIV with div_cnt==0: release, div_done=1, next state RUN. div_start is ignored in this cycle.
  - Total stalled cycles = DIV_CYCLES, counting the div_go cycle.
- load_use (RUN, no higher source): stage_hold=4'b0001, stage_flush=4'b0010, pc_hold=1.
- branch_redirect (RUN, no higher source): stage_flush=4'b0001. If load_use is also set, load_use wins and branch_redirect is ignored this cycle.
- stall_count increments in every cycle where pc_hold=1.
- An asynchronous rst mid-DIV or mid-MEM returns to RUN immediately. No div_abort is issued; the divider is reset by rst itself.

Decomposition:
- Shared package holds: bank index constants (BANK_IFID=0, BANK_IDEX=1, BANK_EXMEM=2, BANK_MEMWB=3), the state encoding (RUN=2'd0, DIV=2'd1, MEM=2'd2) and the 4-bit hold/flush patterns (STALL_LU, STALL_DIV, STALL_MEM, FLUSH_EXC).
- One sub-module, stall_wait_timer: a loadable down-counter used for div_cnt. It is instantiated once; mem_cnt stays inline.

Test Plan:
1. load_use=1 for 1 cycle in RUN -> stage_hold=0001, stage_flush=0010, pc_hold=1 for exactly that cycle; stall_count=1.
2. div_start held high, DIV_CYCLES=16 -> div_go at t0; hold=0011/flush=0100 for cycles t0..t15; div_done and release at t16; stall_count=16.
3. mem_req=1, mem_ack arrives on the 4th cycle -> hold=0111/flush=1000 for 3 cycles; release in the ack cycle; back to RUN.
4. mem_req=1 with no ack, MEM_TIMEOUT=64 -> mem_timeout pulses at cycle 63; release; state RUN.
5. exc_mem=1 at DIV cycle 5 -> flush=0111, hold=0, div_abort=1; state RUN next cycle; no div_done.
6. Priority and reset:
   - load_use and branch_redirect together -> load_use pattern only.
   - rst asserted mid-MEM -> all outputs 0 asynchronously; state RUN after deassert.
